// File: rtl/pipe_pkg.sv
// pipe_pkg -- shared definitions for the pipeline hazard unit.
//
// Contents:
//   DW_DEF, RW_DEF, MD_LAT_DEF : default datapath width, register index width
//                                and multi-cycle (mul/div) result latency.
//   MD_CW                      : width of the multi-cycle countdown register.
//                                Sized so the largest legal latency (15) fits.
//   fwd_sel_e                  : operand source chosen by the forwarding mux.
//   src_hit()                  : "does an ID-stage source read match a producer".
package pipe_pkg;

    localparam int DW_DEF     = 32;
    localparam int RW_DEF     = 5;
    localparam int MD_LAT_DEF = 4;
    localparam int MD_CW      = 4;

    // Listed in priority order; the forwarding mux takes the first match.
    typedef enum logic [2:0] {
        FWD_ZERO = 3'd0,
        FWD_MD   = 3'd1,
        FWD_EALU = 3'd2,
        FWD_MMO  = 3'd3,
        FWD_MALU = 3'd4,
        FWD_WDI  = 3'd5,
        FWD_RF   = 3'd6
    } fwd_sel_e;

    // A producer conflicts with the ID instruction when it writes a register
    // that the instruction actually reads through rs or rt. The index
    // comparisons are done by the caller so this stays width-independent.
    function automatic logic src_hit(
        input logic use_rs,
        input logic rs_match,
        input logic use_rt,
        input logic rt_match
    );
        return (use_rs & rs_match) | (use_rt & rt_match);
    endfunction

endpackage

// File: rtl/pipe_hazard_unit_fwd_sel.sv
// fwd_sel -- operand forwarding mux for one ID-stage source port.
//
// Compares one source register index against every in-flight producer and
// returns both the chosen source and the operand data.
//
// Ports:
//   i_idx                         source register index read by ID
//   i_md_last, i_md_rn, i_md_res  multi-cycle unit: result valid this cycle,
//                                 destination index, result data
//   i_e_*                         EX-stage producer (wreg, m2reg, rn, alu)
//   i_m_*                         MEM-stage producer (wreg, m2reg, rn, alu, mo)
//   i_w_*                         WB-stage producer (wreg, rn, di)
//   i_rf                          register-file read data for this port
//   o_sel                         chosen source
//   o_data                        forwarded operand
module fwd_sel
    import pipe_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic [RW-1:0] i_idx,
    input  logic          i_md_last,
    input  logic [RW-1:0] i_md_rn,
    input  logic [DW-1:0] i_md_res,
    input  logic          i_e_wreg,
    input  logic          i_e_m2reg,
    input  logic [RW-1:0] i_e_rn,
    input  logic [DW-1:0] i_e_alu,
    input  logic          i_m_wreg,
    input  logic          i_m_m2reg,
    input  logic [RW-1:0] i_m_rn,
    input  logic [DW-1:0] i_m_alu,
    input  logic [DW-1:0] i_m_mo,
    input  logic          i_w_wreg,
    input  logic [RW-1:0] i_w_rn,
    input  logic [DW-1:0] i_w_di,
    input  logic [DW-1:0] i_rf,
    output fwd_sel_e      o_sel,
    output logic [DW-1:0] o_data
);

    // A load still in EX has no data yet: it is deliberately skipped here and
    // the hazard logic stalls instead, so a match falls through to older stages.
    always_comb begin
        o_sel = FWD_RF;
        if (i_idx == '0) begin
            o_sel = FWD_ZERO;
        end else if (i_md_last && (i_md_rn == i_idx)) begin
            o_sel = FWD_MD;
        end else if (i_e_wreg && !i_e_m2reg && (i_e_rn == i_idx)) begin
            o_sel = FWD_EALU;
        end else if (i_m_wreg && i_m_m2reg && (i_m_rn == i_idx)) begin
            o_sel = FWD_MMO;
        end else if (i_m_wreg && !i_m_m2reg && (i_m_rn == i_idx)) begin
            o_sel = FWD_MALU;
        end else if (i_w_wreg && (i_w_rn == i_idx)) begin
            o_sel = FWD_WDI;
        end
    end

    always_comb begin
        o_data = i_rf;
        case (o_sel)
            FWD_ZERO: o_data = '0;
            FWD_MD:   o_data = i_md_res;
            FWD_EALU: o_data = i_e_alu;
            FWD_MMO:  o_data = i_m_mo;
            FWD_MALU: o_data = i_m_alu;
            FWD_WDI:  o_data = i_w_di;
            default:  o_data = i_rf;
        endcase
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit -- hazard detection, operand forwarding and multi-cycle
// scoreboard for a 5-stage pipeline with one outstanding mul/div unit.
//
// Ports:
//   i_clock, i_reset          clock; synchronous active-high reset
//   i_d_valid, i_d_md         ID: instruction valid, is a multi-cycle op
//   i_d_wreg                  ID: writes a register
//   i_d_use_rs, i_d_use_rt    ID: reads rs / rt
//   i_d_rs, i_d_rt, i_d_rn    ID: source and destination indices
//   i_rf_a, i_rf_b            register-file read data for rs / rt
//   i_e_*, i_m_*, i_w_*       EX / MEM / WB producers
//   i_flush                   squash the ID instruction (taken branch/jump)
//   i_md_res                  multi-cycle result, meaningful while count==1
//   o_da, o_db                forwarded operands
//   o_stall                   hold PC and IF/ID
//   o_bubble                  insert a NOP into ID/EX
//   o_md_busy, o_md_rn        multi-cycle unit busy, its destination index
//   o_stall_cnt               saturating count of stalled cycles
//
// Handshake: the ID instruction issues in a cycle when i_d_valid=1, o_stall=0
// and i_flush=0; o_stall never asserts without i_d_valid.
//
// MD_LAT must lie in 2..15.
module pipe_hazard_unit
    import pipe_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int RW     = RW_DEF,
    parameter int MD_LAT = MD_LAT_DEF
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_d_valid,
    input  logic          i_d_md,
    input  logic          i_d_wreg,
    input  logic          i_d_use_rs,
    input  logic          i_d_use_rt,
    input  logic [RW-1:0] i_d_rs,
    input  logic [RW-1:0] i_d_rt,
    input  logic [RW-1:0] i_d_rn,
    input  logic [DW-1:0] i_rf_a,
    input  logic [DW-1:0] i_rf_b,
    input  logic          i_e_wreg,
    input  logic          i_e_m2reg,
    input  logic [RW-1:0] i_e_rn,
    input  logic [DW-1:0] i_e_alu,
    input  logic          i_m_wreg,
    input  logic          i_m_m2reg,
    input  logic [RW-1:0] i_m_rn,
    input  logic [DW-1:0] i_m_alu,
    input  logic [DW-1:0] i_m_mo,
    input  logic          i_w_wreg,
    input  logic [RW-1:0] i_w_rn,
    input  logic [DW-1:0] i_w_di,
    input  logic          i_flush,
    input  logic [DW-1:0] i_md_res,
    output logic [DW-1:0] o_da,
    output logic [DW-1:0] o_db,
    output logic          o_stall,
    output logic          o_bubble,
    output logic          o_md_busy,
    output logic [RW-1:0] o_md_rn,
    output logic [31:0]   o_stall_cnt
);

    localparam logic [MD_CW-1:0] MD_LAT_C = MD_CW'(MD_LAT);

    logic [MD_CW-1:0] r_md_cnt;
    logic [RW-1:0]    r_md_rn;
    logic [31:0]      r_stall_cnt;

    logic     w_md_last;
    logic     w_md_long;
    logic     w_use_rs;
    logic     w_use_rt;
    logic     w_load_use;
    logic     w_md_raw;
    logic     w_md_waw;
    logic     w_md_struct;
    logic     w_stall;
    logic     w_issue;
    fwd_sel_e w_sel_a;
    fwd_sel_e w_sel_b;
    logic     w_unused_sel;

    // Count of 1 is the cycle the result appears on i_md_res: readers are
    // served by forwarding rather than stalled, hence the >1 tests below.
    assign w_md_last = (r_md_cnt == MD_CW'(1));
    assign w_md_long = (r_md_cnt >  MD_CW'(1));

    // Reads of r0 never create a dependence.
    assign w_use_rs = i_d_use_rs & (i_d_rs != '0);
    assign w_use_rt = i_d_use_rt & (i_d_rt != '0);

    assign w_load_use = i_e_wreg & i_e_m2reg & (i_e_rn != '0) &
                        src_hit(w_use_rs, i_e_rn == i_d_rs,
                                w_use_rt, i_e_rn == i_d_rt);

    assign w_md_raw = w_md_long & (r_md_rn != '0) &
                      src_hit(w_use_rs, r_md_rn == i_d_rs,
                              w_use_rt, r_md_rn == i_d_rt);

    // A younger writer of the same register must not retire before the
    // multi-cycle result does, or the older value would win.
    assign w_md_waw = w_md_long & i_d_wreg & (i_d_rn == r_md_rn) & (i_d_rn != '0);

    // Only one multi-cycle op may be outstanding; waiting for count 0 also
    // guarantees a new load never collides with the final decrement.
    assign w_md_struct = i_d_md & (r_md_cnt != '0);

    assign w_stall = i_d_valid & (w_load_use | w_md_raw | w_md_waw | w_md_struct);
    assign w_issue = i_d_valid & ~w_stall & ~i_flush;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_md_cnt    <= '0;
            r_md_rn     <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_issue && i_d_md) begin
                r_md_cnt <= MD_LAT_C;
                r_md_rn  <= i_d_rn;
            end else if (r_md_cnt != '0) begin
                r_md_cnt <= r_md_cnt - MD_CW'(1);
            end

            if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    fwd_sel #(.DW(DW), .RW(RW)) u_fwd_a (
        .i_idx     (i_d_rs),
        .i_md_last (w_md_last),
        .i_md_rn   (r_md_rn),
        .i_md_res  (i_md_res),
        .i_e_wreg  (i_e_wreg),
        .i_e_m2reg (i_e_m2reg),
        .i_e_rn    (i_e_rn),
        .i_e_alu   (i_e_alu),
        .i_m_wreg  (i_m_wreg),
        .i_m_m2reg (i_m_m2reg),
        .i_m_rn    (i_m_rn),
        .i_m_alu   (i_m_alu),
        .i_m_mo    (i_m_mo),
        .i_w_wreg  (i_w_wreg),
        .i_w_rn    (i_w_rn),
        .i_w_di    (i_w_di),
        .i_rf      (i_rf_a),
        .o_sel     (w_sel_a),
        .o_data    (o_da)
    );

    fwd_sel #(.DW(DW), .RW(RW)) u_fwd_b (
        .i_idx     (i_d_rt),
        .i_md_last (w_md_last),
        .i_md_rn   (r_md_rn),
        .i_md_res  (i_md_res),
        .i_e_wreg  (i_e_wreg),
        .i_e_m2reg (i_e_m2reg),
        .i_e_rn    (i_e_rn),
        .i_e_alu   (i_e_alu),
        .i_m_wreg  (i_m_wreg),
        .i_m_m2reg (i_m_m2reg),
        .i_m_rn    (i_m_rn),
        .i_m_alu   (i_m_alu),
        .i_m_mo    (i_m_mo),
        .i_w_wreg  (i_w_wreg),
        .i_w_rn    (i_w_rn),
        .i_w_di    (i_w_di),
        .i_rf      (i_rf_b),
        .o_sel     (w_sel_b),
        .o_data    (o_db)
    );

    // Select codes are kept on the sub-module for observability only.
    assign w_unused_sel = ^{w_sel_a, w_sel_b};

    assign o_stall     = w_stall;
    assign o_bubble    = w_stall | i_flush;
    assign o_md_busy   = (r_md_cnt != '0);
    assign o_md_rn     = r_md_rn;
    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
module tb_pipe_hazard_unit;

    logic        clk;
    logic        rst;
    logic        d_valid, d_md, d_wreg, d_use_rs, d_use_rt;
    logic [4:0]  d_rs, d_rt, d_rn;
    logic [31:0] rf_a, rf_b;
    logic        e_wreg, e_m2reg;
    logic [4:0]  e_rn;
    logic [31:0] e_alu;
    logic        m_wreg, m_m2reg;
    logic [4:0]  m_rn;
    logic [31:0] m_alu, m_mo;
    logic        w_wreg;
    logic [4:0]  w_rn;
    logic [31:0] w_di;
    logic        flush;
    logic [31:0] md_res;
    logic [31:0] da, db;
    logic        stall, bubble, md_busy;
    logic [4:0]  md_rn;
    logic [31:0] stall_cnt;

    logic [31:0] exp_q[$];
    int          n_checks;
    int          n_errors;
    logic        exp_stall_now;
    logic [31:0] exp_sc;

    pipe_hazard_unit dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_d_valid   (d_valid),
        .i_d_md      (d_md),
        .i_d_wreg    (d_wreg),
        .i_d_use_rs  (d_use_rs),
        .i_d_use_rt  (d_use_rt),
        .i_d_rs      (d_rs),
        .i_d_rt      (d_rt),
        .i_d_rn      (d_rn),
        .i_rf_a      (rf_a),
        .i_rf_b      (rf_b),
        .i_e_wreg    (e_wreg),
        .i_e_m2reg   (e_m2reg),
        .i_e_rn      (e_rn),
        .i_e_alu     (e_alu),
        .i_m_wreg    (m_wreg),
        .i_m_m2reg   (m_m2reg),
        .i_m_rn      (m_rn),
        .i_m_alu     (m_alu),
        .i_m_mo      (m_mo),
        .i_w_wreg    (w_wreg),
        .i_w_rn      (w_rn),
        .i_w_di      (w_di),
        .i_flush     (flush),
        .i_md_res    (md_res),
        .o_da        (da),
        .o_db        (db),
        .o_stall     (stall),
        .o_bubble    (bubble),
        .o_md_busy   (md_busy),
        .o_md_rn     (md_rn),
        .o_stall_cnt (stall_cnt)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Scoreboard: expected value queued at drive time, popped at compare time.
    task automatic push_exp(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic compare(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        e = exp_q.pop_front();
        n_checks++;
        assert (obs === e) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        push_exp(exp);
        compare(tag, obs);
    endtask

    task automatic chk_stall(input string tag, input logic exp_s);
        chk(tag, {31'd0, stall}, {31'd0, exp_s});
        chk({tag, "_bub"}, {31'd0, bubble}, {31'd0, exp_s | flush});
        exp_stall_now = exp_s;
    endtask

    // Advance one clock; the stall-counter model follows the bench's own
    // expectation of stall at that edge.
    task automatic step();
        @(posedge clk);
        if (rst) exp_sc = 32'd0;
        else if (exp_stall_now && exp_sc != 32'hFFFF_FFFF) exp_sc = exp_sc + 32'd1;
        #1;
    endtask

    task automatic clear();
        d_valid = 0; d_md = 0; d_wreg = 0; d_use_rs = 0; d_use_rt = 0;
        d_rs = 0; d_rt = 0; d_rn = 0;
        rf_a = 32'hA0A0_A0A0; rf_b = 32'hB0B0_B0B0;
        e_wreg = 0; e_m2reg = 0; e_rn = 0; e_alu = 32'hE0E0_E0E0;
        m_wreg = 0; m_m2reg = 0; m_rn = 0; m_alu = 32'hC0C0_C0C0; m_mo = 32'hD0D0_D0D0;
        w_wreg = 0; w_rn = 0; w_di = 32'hF0F0_F0F0;
        flush = 0; md_res = 32'h0BAD_0BAD;
        exp_stall_now = 0;
    endtask

    // Reference forwarding priority with the multi-cycle unit idle.
    function automatic logic [31:0] model_fwd(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 5'd0) return 32'd0;
        if (e_wreg && !e_m2reg && e_rn == idx) return e_alu;
        if (m_wreg && m_m2reg && m_rn == idx) return m_mo;
        if (m_wreg && !m_m2reg && m_rn == idx) return m_alu;
        if (w_wreg && w_rn == idx) return w_di;
        return rf;
    endfunction

    task automatic issue_md(input logic [4:0] rn);
        clear();
        d_valid = 1; d_md = 1; d_wreg = 1; d_rn = rn;
        #1;
        chk_stall("md_issue", 1'b0);
        step();
        clear();
    endtask

    task automatic set_load_use();
        clear();
        e_wreg = 1; e_m2reg = 1; e_rn = 5'd2; e_alu = 32'h999;
        d_valid = 1; d_use_rs = 1; d_rs = 5'd2; d_wreg = 1; d_rn = 5'd4;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_sc   = 0;
        clear();

        // Reset state
        rst = 1;
        step();
        step();
        d_valid = 1; d_use_rs = 1; d_rs = 5'd5;
        #1;
        chk("rst_busy", {31'd0, md_busy}, 32'd0);
        chk("rst_md_rn", {27'd0, md_rn}, 32'd0);
        chk("rst_sc", stall_cnt, 32'd0);
        chk_stall("rst_stall", 1'b0);
        chk("rst_da", da, 32'hA0A0_A0A0);
        rst = 0;
        step();

        // Forwarding priority, directed
        clear();
        e_wreg = 1; e_rn = 5'd3; e_alu = 32'h11;
        m_wreg = 1; m_rn = 5'd3; m_alu = 32'h22;
        d_valid = 1; d_use_rs = 1; d_rs = 5'd3;
        #1;
        chk("fwd_ealu", da, 32'h11);
        step();
        e_wreg = 0;
        #1;
        chk("fwd_malu", da, 32'h22);
        step();
        m_m2reg = 1; m_mo = 32'h33; e_wreg = 1; e_m2reg = 1; e_rn = 5'd7;
        #1;
        chk("fwd_mmo", da, 32'h33);
        step();
        m_wreg = 0; e_wreg = 0; w_wreg = 1; w_rn = 5'd3; w_di = 32'h44;
        d_use_rt = 1; d_rt = 5'd3;
        #1;
        chk("fwd_wdi_a", da, 32'h44);
        chk("fwd_wdi_b", db, 32'h44);
        step();
        d_rs = 5'd0; d_rt = 5'd9;
        #1;
        chk("fwd_zero", da, 32'd0);
        chk("fwd_rf_b", db, 32'hB0B0_B0B0);
        step();

        // Forwarding priority, random
        for (int i = 0; i < 24; i++) begin
            clear();
            e_wreg = 1'($urandom_range(0, 1)); e_m2reg = 1'($urandom_range(0, 1));
            e_rn = 5'($urandom_range(0, 3)); e_alu = $urandom;
            m_wreg = 1'($urandom_range(0, 1)); m_m2reg = 1'($urandom_range(0, 1));
            m_rn = 5'($urandom_range(0, 3)); m_alu = $urandom; m_mo = $urandom;
            w_wreg = 1'($urandom_range(0, 1)); w_rn = 5'($urandom_range(0, 3)); w_di = $urandom;
            d_rs = 5'($urandom_range(0, 3)); d_rt = 5'($urandom_range(0, 3));
            d_use_rs = 1; d_use_rt = 1;
            rf_a = $urandom; rf_b = $urandom;
            push_exp(model_fwd(d_rs, rf_a));
            push_exp(model_fwd(d_rt, rf_b));
            #1;
            compare("rnd_da", da);
            compare("rnd_db", db);
            chk_stall("rnd_nostall", 1'b0);
            step();
        end

        // Load-use hazard
        set_load_use();
        #1;
        chk_stall("lu_stall", 1'b1);
        step();
        clear();
        m_wreg = 1; m_m2reg = 1; m_rn = 5'd2; m_mo = 32'h55;
        d_valid = 1; d_use_rs = 1; d_rs = 5'd2; d_wreg = 1; d_rn = 5'd4;
        #1;
        chk_stall("lu_release", 1'b0);
        chk("lu_da_mo", da, 32'h55);
        chk("lu_sc", stall_cnt, exp_sc);
        step();
        set_load_use();
        d_use_rs = 0; d_use_rt = 1; d_rs = 5'd7; d_rt = 5'd2;
        #1;
        chk_stall("lu_rt", 1'b1);
        step();
        set_load_use();
        d_use_rs = 0;
        #1;
        chk_stall("lu_unused", 1'b0);
        step();
        set_load_use();
        e_rn = 5'd0; d_rs = 5'd0;
        #1;
        chk_stall("lu_r0", 1'b0);
        step();
        set_load_use();
        d_valid = 0;
        #1;
        chk_stall("lu_invalid", 1'b0);
        step();

        // Flushed md op never issues
        clear();
        d_valid = 1; d_md = 1; d_wreg = 1; d_rn = 5'd6; flush = 1;
        #1;
        chk_stall("fl_md", 1'b0);
        step();
        clear();
        #1;
        chk("fl_md_busy", {31'd0, md_busy}, 32'd0);

        // Flush during load-use stall with an md op in flight
        issue_md(5'd7);
        set_load_use();
        flush = 1;
        #1;
        chk_stall("fl_lu", 1'b1);
        chk("fl_lu_busy", {31'd0, md_busy}, 32'd1);
        step();
        clear();
        d_valid = 1; d_use_rs = 1; d_rs = 5'd7; md_res = 32'h7777;
        #1;
        chk_stall("fl_raw3", 1'b1);
        step();
        chk_stall("fl_raw2", 1'b1);
        step();
        chk_stall("fl_raw1", 1'b0);
        chk("fl_md_res", da, 32'h7777);
        step();
        clear();
        #1;
        chk("fl_done_busy", {31'd0, md_busy}, 32'd0);
        chk("fl_held_rn", {27'd0, md_rn}, 32'd7);
        chk("fl_sc", stall_cnt, exp_sc);

        // mul r5 then dependent read: 3 stall cycles
        rst = 1;
        step();
        rst = 0;
        issue_md(5'd5);
        chk("mul_busy", {31'd0, md_busy}, 32'd1);
        chk("mul_rn", {27'd0, md_rn}, 32'd5);
        d_valid = 1; d_use_rs = 1; d_rs = 5'd5; d_use_rt = 1; d_rt = 5'd5;
        d_wreg = 1; d_rn = 5'd8; md_res = 32'hDEAD;
        #1;
        chk_stall("mul_s4", 1'b1);
        step();
        chk_stall("mul_s3", 1'b1);
        step();
        chk_stall("mul_s2", 1'b1);
        step();
        chk_stall("mul_s1", 1'b0);
        chk("mul_da", da, 32'hDEAD);
        chk("mul_db", db, 32'hDEAD);
        chk("mul_sc3", stall_cnt, 32'd3);
        step();
        clear();
        #1;
        chk("mul_idle", {31'd0, md_busy}, 32'd0);
        chk("mul_rn_held", {27'd0, md_rn}, 32'd5);

        // Second mul waits for count 0; WAW waits while count > 1
        issue_md(5'd5);
        d_valid = 1; d_md = 1; d_wreg = 1; d_rn = 5'd9; d_use_rs = 1; d_rs = 5'd1;
        #1;
        chk_stall("st_4", 1'b1);
        step();
        chk_stall("st_3", 1'b1);
        step();
        chk_stall("st_2", 1'b1);
        step();
        chk_stall("st_1", 1'b1);
        step();
        chk_stall("st_0", 1'b0);
        step();
        clear();
        #1;
        chk("st_rn9", {27'd0, md_rn}, 32'd9);
        chk("st_busy", {31'd0, md_busy}, 32'd1);
        d_valid = 1; d_wreg = 1; d_rn = 5'd9;
        #1;
        chk_stall("waw_4", 1'b1);
        step();
        chk_stall("waw_3", 1'b1);
        step();
        chk_stall("waw_2", 1'b1);
        step();
        chk_stall("waw_1", 1'b0);
        step();
        clear();
        #1;
        chk("waw_idle", {31'd0, md_busy}, 32'd0);
        chk("waw_sc", stall_cnt, exp_sc);

        // Reset mid-md
        issue_md(5'd3);
        rst = 1;
        step();
        rst = 0;
        chk("rm_busy", {31'd0, md_busy}, 32'd0);
        chk("rm_sc", stall_cnt, 32'd0);
        chk("rm_rn", {27'd0, md_rn}, 32'd0);
        d_valid = 1; d_use_rs = 1; d_rs = 5'd3; rf_a = 32'h1234;
        #1;
        chk_stall("rm_stall", 1'b0);
        chk("rm_da", da, 32'h1234);
        step();

        // Saturation of the stall counter, preloaded near max
        set_load_use();
        #1;
        chk_stall("sat_stall", 1'b1);
        dut.r_stall_cnt = 32'hFFFF_FFFD;
        exp_sc = 32'hFFFF_FFFD;
        step();
        chk("sat_fe", stall_cnt, 32'hFFFF_FFFE);
        step();
        chk("sat_ff", stall_cnt, 32'hFFFF_FFFF);
        step();
        step();
        step();
        chk("sat_hold", stall_cnt, 32'hFFFF_FFFF);
        chk("sat_model", stall_cnt, exp_sc);
        clear();
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
